ifetch: RTL and testbench

Instruction fetch stage of the single-cycle RISC-V core, sitting directly upstream of the main decoder. Holds the program counter, fetches each instruction from instruction memory over a req/ack handshake, presents the instruction and its 7-bit opcode to the decoder, and advances the PC on retire. The next PC is PC+4, or PC+immext when the decoder's `pcsrc` is high (taken branch or `jal`).

---
 rtl/ifetch.sv | 88 ++++++++
 tb/tb_ifetch.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake,
// presents the instruction to the decoder and advances the PC on retire.
module ifetch #(
  parameter logic [31:0] RESETPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imemreq,
  output logic [31:0] imemaddr,
  input  logic        imemack,
  input  logic [31:0] imemrdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instrvalid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        pcsrc,
  input  logic [31:0] immext,
  input  logic        retire,
  output logic        fault,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic [31:0] pcplus4_d;
  logic [31:0] target_d;

  // Next-PC candidates; only consumed on the retire edge in EXEC
  always_comb begin
    pcplus4_d = pc_q + 32'd4;
    target_d  = pcsrc ? (pc_q + immext) : pcplus4_d;
  end

  // Fetch/execute sequencer with PC, instruction and retire-count state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pc_q      <= RESETPC;
      instr_q   <= NOP;
      instret_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imemack) begin
            instr_q <= imemrdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            instret_q <= instret_q + 32'd1;
            // A misaligned target freezes the PC at the offending instruction
            if (target_d[1:0] != 2'b00) begin
              state_q <= FAULT;
            end else begin
              pc_q    <= target_d;
              state_q <= FETCH;
            end
          end
        end
        FAULT: state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    imemreq    = (state_q == FETCH);
    instrvalid = (state_q == EXEC);
    fault      = (state_q == FAULT);
    imemaddr   = pc_q;
    pc         = pc_q;
    pcplus4    = pcplus4_d;
    instr      = instr_q;
    opcode     = instr_q[6:0];
    instret    = instret_q;
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, fetch/retire sequencing, branches,
// PC wrap, misalignment fault, reset mid-fetch and delayed ack.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        imemreq, instrvalid, fault;
  logic [31:0] imemaddr, instr, pc, pcplus4, instret;
  logic [6:0]  opcode;
  logic        imemack, pcsrc, retire;
  logic [31:0] imemrdata, immext;

  logic        imemreq2, instrvalid2, fault2;
  logic [31:0] imemaddr2, instr2, pc2, pcplus42, instret2;
  logic [6:0]  opcode2;
  logic        imemack2;
  logic [31:0] imemrdata2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ifetch u_dut (
    .clk(clk), .resetn(resetn), .imemreq(imemreq), .imemaddr(imemaddr),
    .imemack(imemack), .imemrdata(imemrdata), .instr(instr), .opcode(opcode),
    .instrvalid(instrvalid), .pc(pc), .pcplus4(pcplus4), .pcsrc(pcsrc),
    .immext(immext), .retire(retire), .fault(fault), .instret(instret)
  );

  ifetch #(.RESETPC(32'h0000_0100)) u_dut2 (
    .clk(clk), .resetn(resetn), .imemreq(imemreq2), .imemaddr(imemaddr2),
    .imemack(imemack2), .imemrdata(imemrdata2), .instr(instr2), .opcode(opcode2),
    .instrvalid(instrvalid2), .pc(pc2), .pcplus4(pcplus42), .pcsrc(1'b0),
    .immext(32'd0), .retire(1'b0), .fault(fault2), .instret(instret2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] d);
    imemack = 1'b1; imemrdata = d;
    tick();
    imemack = 1'b0;
  endtask

  task automatic do_retire(input logic src, input logic [31:0] imm);
    retire = 1'b1; pcsrc = src; immext = imm;
    tick();
    retire = 1'b0; pcsrc = 1'b0; immext = 32'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_total++; if (imemreq !== 1'b0) $display("FAIL rst_imemreq got=%b exp=0", imemreq); else n_pass++;
    n_total++; if (instr !== 32'h13) $display("FAIL rst_instr got=%h exp=00000013", instr); else n_pass++;
    n_total++; if (opcode !== 7'h13) $display("FAIL rst_opcode got=%h exp=13", opcode); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL rst_pc got=%h exp=0", pc); else n_pass++;
    n_total++; if ({instrvalid, fault} !== 2'b00) $display("FAIL rst_valid_fault got=%b exp=00", {instrvalid, fault}); else n_pass++;
    n_total++; if (instret !== 32'h0) $display("FAIL rst_instret got=%h exp=0", instret); else n_pass++;
  endtask

  task automatic test_first_fetch();
    resetn = 1'b1;
    n_total++; if (imemreq !== 1'b0) $display("FAIL ff_req_at_release got=%b exp=0", imemreq); else n_pass++;
    tick();
    n_total++; if (imemreq !== 1'b1 || imemaddr !== 32'h0) $display("FAIL ff_req got=%b/%h exp=1/00000000", imemreq, imemaddr); else n_pass++;
    do_fetch(32'h0080_006F);
    n_total++; if (instrvalid !== 1'b1 || imemreq !== 1'b0) $display("FAIL ff_valid got=%b/%b exp=1/0", instrvalid, imemreq); else n_pass++;
    n_total++; if (instr !== 32'h0080_006F || opcode !== 7'h6F) $display("FAIL ff_instr got=%h/%h exp=0080006f/6f", instr, opcode); else n_pass++;
    do_retire(1'b0, 32'h0);
    n_total++; if (imemaddr !== 32'h4 || imemreq !== 1'b1) $display("FAIL ff_next got=%h/%b exp=00000004/1", imemaddr, imemreq); else n_pass++;
    n_total++; if (instret !== 32'd1) $display("FAIL ff_instret got=%0d exp=1", instret); else n_pass++;
    n_total++; if (pcplus4 !== 32'h8) $display("FAIL ff_pcplus4 got=%h exp=00000008", pcplus4); else n_pass++;
  endtask

  task automatic test_branch();
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'h0000_001C);
    n_total++; if (imemaddr !== 32'h20) $display("FAIL br_to20 got=%h exp=00000020", imemaddr); else n_pass++;
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'hFFFF_FFF0);
    n_total++; if (imemaddr !== 32'h10) $display("FAIL br_back got=%h exp=00000010", imemaddr); else n_pass++;
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'h0000_0010);
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'h0000_0008);
    n_total++; if (imemaddr !== 32'h28) $display("FAIL br_fwd got=%h exp=00000028", imemaddr); else n_pass++;
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'hFFFF_FFF8);
    n_total++; if (pc !== 32'h20 || instret !== 32'd6) $display("FAIL br_end got=%h/%0d exp=00000020/6", pc, instret); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_fetch(32'h0000_0013);
    n_total++; if (instrvalid !== 1'b1) $display("FAIL b2b_exec1 got=%b exp=1", instrvalid); else n_pass++;
    do_retire(1'b0, 32'h0);
    n_total++; if (imemreq !== 1'b1 || imemaddr !== 32'h24) $display("FAIL b2b_fetch2 got=%b/%h exp=1/00000024", imemreq, imemaddr); else n_pass++;
    do_fetch(32'h0000_0033);
    n_total++; if (instrvalid !== 1'b1 || opcode !== 7'h33) $display("FAIL b2b_exec2 got=%b/%h exp=1/33", instrvalid, opcode); else n_pass++;
    do_retire(1'b0, 32'h0);
    n_total++; if (imemaddr !== 32'h28 || instret !== 32'd8) $display("FAIL b2b_end got=%h/%0d exp=00000028/8", imemaddr, instret); else n_pass++;
    // Retire held while in FETCH must be ignored
    retire = 1'b1; tick(); retire = 1'b0;
    n_total++; if (imemaddr !== 32'h28 || instret !== 32'd8 || imemreq !== 1'b1) $display("FAIL b2b_retire_in_fetch got=%h/%0d/%b exp=00000028/8/1", imemaddr, instret, imemreq); else n_pass++;
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'hFFFF_FFF8);
  endtask

  task automatic test_wrap();
    do_fetch(32'h0000_006F); do_retire(1'b1, 32'hFFFF_FFDC);
    n_total++; if (imemaddr !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) $display("FAIL wrap_top got=%h/%h exp=fffffffc/00000000", imemaddr, pcplus4); else n_pass++;
    do_fetch(32'h0000_0013); do_retire(1'b0, 32'h0);
    n_total++; if (imemaddr !== 32'h0 || fault !== 1'b0 || imemreq !== 1'b1) $display("FAIL wrap_zero got=%h/%b/%b exp=00000000/0/1", imemaddr, fault, imemreq); else n_pass++;
    n_total++; if (instret !== 32'd11) $display("FAIL wrap_instret got=%0d exp=11", instret); else n_pass++;
    do_fetch(32'h0000_006F); do_retire(1'b1, 32'h0000_0020);
  endtask

  task automatic test_fault();
    do_fetch(32'h0000_0063); do_retire(1'b1, 32'h0000_0006);
    n_total++; if (fault !== 1'b1 || imemreq !== 1'b0 || instrvalid !== 1'b0) $display("FAIL flt_enter got=%b%b%b exp=100", fault, imemreq, instrvalid); else n_pass++;
    n_total++; if (pc !== 32'h20 || instret !== 32'd13) $display("FAIL flt_pc got=%h/%0d exp=00000020/13", pc, instret); else n_pass++;
    imemack = 1'b1; retire = 1'b1; pcsrc = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    imemack = 1'b0; retire = 1'b0;
    n_total++; if (fault !== 1'b1 || imemreq !== 1'b0 || pc !== 32'h20 || instret !== 32'd13) $display("FAIL flt_sticky got=%b/%b/%h/%0d exp=1/0/00000020/13", fault, imemreq, pc, instret); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    n_total++; if (imemreq !== 1'b1 || fault !== 1'b0) $display("FAIL rmf_fetching got=%b/%b exp=1/0", imemreq, fault); else n_pass++;
    tick(); tick();
    resetn = 1'b0; #1;
    n_total++; if (imemreq !== 1'b0) $display("FAIL rmf_async_drop got=%b exp=0", imemreq); else n_pass++;
    n_total++; if (instr !== 32'h13 || pc !== 32'h0 || instret !== 32'd0) $display("FAIL rmf_regs got=%h/%h/%0d exp=00000013/00000000/0", instr, pc, instret); else n_pass++;
    tick();
    resetn = 1'b1; imemack = 1'b1; imemrdata = 32'hDEAD_BEEF;
    tick();
    imemack = 1'b0;
    n_total++; if (instr !== 32'h13 || instrvalid !== 1'b0) $display("FAIL rmf_late_ack got=%h/%b exp=00000013/0", instr, instrvalid); else n_pass++;
    n_total++; if (imemreq !== 1'b1 || imemaddr !== 32'h0) $display("FAIL rmf_restart got=%b/%h exp=1/00000000", imemreq, imemaddr); else n_pass++;
    do_fetch(32'h0000_0537);
    n_total++; if (instrvalid !== 1'b1 || opcode !== 7'h37) $display("FAIL rmf_fetch got=%b/%h exp=1/37", instrvalid, opcode); else n_pass++;
    // Reset while in EXEC discards the instruction without counting it
    retire = 1'b1; resetn = 1'b0; tick(); retire = 1'b0;
    n_total++; if (instret !== 32'd0 || instrvalid !== 1'b0) $display("FAIL rmf_exec_rst got=%0d/%b exp=0/0", instret, instrvalid); else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_delayed_ack();
    imemack2 = 1'b0;
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (imemreq2 !== 1'b1 || imemaddr2 !== 32'h100 || instrvalid2 !== 1'b0) $display("FAIL dly_wait%0d got=%b/%h/%b exp=1/00000100/0", i, imemreq2, imemaddr2, instrvalid2); else n_pass++;
      tick();
    end
    imemack2 = 1'b1; imemrdata2 = 32'h0000_0017;
    n_total++; if (imemreq2 !== 1'b1 || imemaddr2 !== 32'h100 || instrvalid2 !== 1'b0) $display("FAIL dly_ackcyc got=%b/%h/%b exp=1/00000100/0", imemreq2, imemaddr2, instrvalid2); else n_pass++;
    tick();
    imemack2 = 1'b0;
    n_total++; if (instrvalid2 !== 1'b1 || instr2 !== 32'h17 || pc2 !== 32'h100) $display("FAIL dly_valid got=%b/%h/%h exp=1/00000017/00000100", instrvalid2, instr2, pc2); else n_pass++;
  endtask

  initial begin
    resetn = 1'b0; imemack = 1'b0; imemrdata = 32'h0; pcsrc = 1'b0;
    immext = 32'h0; retire = 1'b0; imemack2 = 1'b0; imemrdata2 = 32'h0;
    #1;
    test_reset();
    test_first_fetch();
    test_branch();
    test_back_to_back();
    test_wrap();
    test_fault();
    test_reset_mid_fetch();
    test_delayed_ack();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
